sum_seg_display: RTL and testbench
==================================

# sum_seg_display

Display stage downstream of the serial accumulator. Takes the 8-bit running sum and the done flag from the accumulator top level and shows them on a 4-digit, common-anode seven-segment display. Conversion uses a sequential double-dabble binary-to-BCD converter; digits are time-multiplexed with a refresh divider. Digit 3 (leftmost) is a status digit, and digits 2..0 show the decimal sum 0..255.

## Interface
- `SIM`, default 0: 1 selects the short refresh period for simulation.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot when `SIM`=0.
- `SIM_DIV`, default 4: clock cycles per digit slot when `SIM`=1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1: system clock.
- `reset`  input  1: synchronous reset, active-high.
- `sum_in`  input  8: accumulator sum, binary.
- `done_in`  input  1: accumulator done flag.
- `an`  output  4: digit anodes, active-low, one-hot; `an[0]` is the rightmost digit.
- `seg`  output  7: segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp`  output  1: decimal point, active-low; constant 1 (off).
- `busy`  output  1: conversion in progress.

## Operation
- `last_val` register holds the last converted `sum_in`.
- FSM states: IDLE, CONVERT, LOAD.
  - **IDLE**: when `sum_in` != `last_val`, capture `sum_in` into the shift register and `last_val`, clear the 12-bit BCD register, set bit counter to 0, and go to CONVERT.
  - **CONVERT**: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, shift} left by 1 and increment the counter. After the 8th shift, go to LOAD.
  - **LOAD**: copy BCD into display registers `d2`/`d1`/`d0`, then go to IDLE.
- `sum_in` changes during CONVERT/LOAD are ignored. The final value is re-detected in IDLE, so the last-stable value is always displayed.
- `done_in` is sampled directly into the digit-3 selection with no conversion. When 1, digit 3 shows "d" (`seg`=7'b0100001); when 0, it is blank (7'b1111111).
- Digit patterns, gfedcba active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Mux order: digit 0 → 1 → 2 → 3 → 0. `an` and `seg` are registered together, so they never show a mismatched digit/pattern.

## Timing
- Reset values:
  - state IDLE, `last_val`=0, `d2`/`d1`/`d0`=0, `busy`=0.
  - digit index 0, refresh counter 0.
  - `an`=4'b1110, `seg`=1000000 ("0"), `dp`=1.
- Conversion latency (E0 = the edge at which IDLE detects the change):
  - `busy`=1 from after E0 through E9.
  - CONVERT occupies E1..E8.
  - LOAD executes at E9: display registers updated and `busy`=0 after E9.
  - New patterns appear on `seg` at the next edge where that digit is selected.
- Refresh timing:
  - Refresh counter counts 0..DIV-1, where DIV = `SIM` ? `SIM_DIV` : `REFRESH_DIV`.
  - At the wrap, the digit index advances, and `an`/`seg` update on the same edge.
  - Each digit is held for exactly DIV cycles; full frame = 4×DIV.
- Simultaneous events: a `sum_in` change on the same edge that LOAD executes is caught on the following IDLE edge.
- Reset mid-conversion: all state returns to reset values on the next edge and the partial BCD is discarded.

## Configuration
- `SUM_DISP_LZ_BLANK_EN`, leading-zero blanking:
  - **Defined**: `d2` is blank when `d2`=0. `d1` is blank when `d2`=0 and `d1`=0. `d0` is always shown. Reset display is "   0".
  - **Undefined**: all three digits are always shown, e.g. 7 displays as "007".
- Status digit 3 is unaffected in both cases.

## Test plan
- **Reset**: assert `reset` 2 cycles → `an`=1110, `seg`=1000000, `dp`=1, `busy`=0; after 4×`SIM_DIV` cycles `an` returns to 1110.
- **Max value**: with `SIM`=1, `sum_in`=255 → `busy` high exactly 9 cycles. Then frame shows digit0=0010010 (5), digit1=0010010 (5), digit2=0100100 (2).
- **Blanking**: `sum_in`=7 → with `SUM_DISP_LZ_BLANK_EN`, digits 2,1 = 1111111 and digit0 = 1111000. Without it, digits 2,1 = 1000000.
- **Status digit**: `done_in`=1 → digit 3 slot shows 0100001; `done_in`=0 → 1111111.
- **Change during conversion**: `sum_in`=100, then 3 cycles later `sum_in`=42 → first conversion completes showing 100. A second `busy` burst of 9 cycles follows, and final digits read 0,4,2 (blanked: " 42").
- **Reset mid-conversion**: `sum_in`=200, assert `reset` at E4 → `busy`=0, display "0". After release, 200 is re-detected (`last_val`=0) and displayed 10 cycles later.

Source files
------------

// File: rtl/sum_seg_display.sv
// sum_seg_display: shows an 8-bit accumulator sum as three decimal digits plus a
// status digit on a 4-digit common-anode seven-segment display.
//
// Binary-to-BCD conversion is a sequential double-dabble (one bit per cycle).
// Digits are time-multiplexed; each digit slot lasts DIV clock cycles, where
// DIV = SIM ? SIM_DIV : REFRESH_DIV.
//
// Optional feature: define SUM_DISP_LZ_BLANK_EN to blank leading zeros on the
// hundreds and tens digits. Without it, all three decimal digits are shown.

module sum_seg_display #(
  parameter int unsigned SIM         = 0,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned SIM_DIV     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sum_in,
  input  logic       done_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int unsigned Div  = (SIM != 0) ? SIM_DIV : REFRESH_DIV;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDone  = 7'b0100001;
  localparam logic [6:0] SegZero  = 7'b1000000;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StLoad
  } state_e;

  // Active-low gfedcba pattern for one BCD digit; non-decimal codes go blank.
  function automatic logic [6:0] digit_pattern(input logic [3:0] v);
    logic [6:0] p;
    unique case (v)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = SegBlank;
    endcase
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion datapath
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  d2_q, d2_d;
  logic [3:0]  d1_q, d1_d;
  logic [3:0]  d0_q, d0_d;
  logic [11:0] bcd_adj;

  // Converter state register; reset discards any partial conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      last_q    <= '0;
      shift_q   <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      d2_q      <= '0;
      d1_q      <= '0;
      d0_q      <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      d2_q      <= d2_d;
      d1_q      <= d1_d;
      d0_q      <= d0_d;
    end
  end

  // Converter next-state: detect change, run 8 double-dabble steps, then load.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    d2_d      = d2_q;
    d1_d      = d1_q;
    d0_d      = d0_q;
    bcd_adj   = bcd_q;

    unique case (state_q)
      StIdle: begin
        if (sum_in != last_q) begin
          shift_d   = sum_in;
          last_d    = sum_in;
          bcd_d     = '0;
          bit_cnt_d = '0;
          state_d   = StConvert;
        end
      end
      StConvert: begin
        for (int i = 0; i < 3; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
          end
        end
        // Max input 255 never reaches bit 11 before the final shift, so dropping it is safe.
        {bcd_d, shift_d} = {bcd_adj[10:0], shift_q, 1'b0};
        bit_cnt_d        = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        d2_d    = bcd_q[11:8];
        d1_d    = bcd_q[7:4];
        d0_d    = bcd_q[3:0];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  // ---------------------------------------------------------------------------
  // Digit patterns (with optional leading-zero blanking)
  // ---------------------------------------------------------------------------
  logic [6:0] pat2, pat1, pat0;

  // Per-digit segment patterns for the three decimal positions.
  always_comb begin
    pat2 = digit_pattern(d2_q);
    pat1 = digit_pattern(d1_q);
    pat0 = digit_pattern(d0_q);
`ifdef SUM_DISP_LZ_BLANK_EN
    if (d2_q == 4'd0) begin
      pat2 = SegBlank;
      if (d1_q == 4'd0) begin
        pat1 = SegBlank;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Refresh multiplexer
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] refresh_q, refresh_d;
  logic [1:0]      digit_q, digit_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  // Refresh counter, digit index and the registered anode/segment pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
      digit_q   <= 2'd0;
      an_q      <= 4'b1110;
      seg_q     <= SegZero;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  // At the end of each slot, advance the digit and load its anode and pattern together.
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    digit_d   = digit_q;
    an_d      = an_q;
    seg_d     = seg_q;
    if (refresh_q == CntW'(Div - 1)) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
      an_d      = ~(4'b0001 << digit_d);
      unique case (digit_d)
        2'd0:    seg_d = pat0;
        2'd1:    seg_d = pat1;
        2'd2:    seg_d = pat2;
        default: seg_d = done_in ? SegDone : SegBlank;
      endcase
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_sum_seg_display.sv
// Testbench for sum_seg_display: directed corner cases plus randomized sums,
// checked against a decimal-arithmetic reference of the displayed frame.
// Honors SUM_DISP_LZ_BLANK_EN the same way the design does.

module tb_sum_seg_display;

  localparam int unsigned Div = 4;

  localparam logic [6:0] Blank = 7'b1111111;
  localparam logic [6:0] DChar = 7'b0100001;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sum_in;
  logic       done_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int last_val = 0;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  sum_seg_display #(
    .SIM        (1),
    .REFRESH_DIV(100000),
    .SIM_DIV    (Div)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sum_in (sum_in),
    .done_in(done_in),
    .an     (an),
    .seg    (seg),
    .dp     (dp),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Length of the next busy burst in cycles; -1 when no complete burst is seen.
  task automatic measure_busy(output int len);
    bit seen = 0;
    len = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1;
        len++;
      end else if (seen) begin
        return;
      end
    end
    len = -1;
  endtask

  // Let every slot refresh, then observe one full frame and compare to the decimal model.
  task automatic check_frame(input int v, input bit dn, input string tag);
    logic [6:0] exp_seg [4];
    logic [6:0] got_seg [4];
    int seen [4];
    int bad_an = 0;
    int bad_dp = 0;
    int h = v / 100;
    int t = (v / 10) % 10;
    int o = v % 10;
    exp_seg[0] = pat[o];
    exp_seg[1] = pat[t];
    exp_seg[2] = pat[h];
`ifdef SUM_DISP_LZ_BLANK_EN
    if (h == 0) exp_seg[2] = Blank;
    if (h == 0 && t == 0) exp_seg[1] = Blank;
`endif
    exp_seg[3] = dn ? DChar : Blank;
    for (int i = 0; i < 4; i++) begin
      seen[i] = 0;
      got_seg[i] = 7'h00;
    end
    repeat (4 * Div) @(negedge clk);
    for (int k = 0; k < 4 * Div; k++) begin
      @(negedge clk);
      if (dp !== 1'b1) bad_dp++;
      case (an)
        4'b1110: begin got_seg[0] = seg; seen[0]++; end
        4'b1101: begin got_seg[1] = seg; seen[1]++; end
        4'b1011: begin got_seg[2] = seg; seen[2]++; end
        4'b0111: begin got_seg[3] = seg; seen[3]++; end
        default: bad_an++;
      endcase
    end
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s digit%0d v=%0d", tag, i, v), 32'(got_seg[i]), 32'(exp_seg[i]));
      check_eq($sformatf("%s hold%0d", tag, i), 32'(seen[i]), Div);
    end
    check_eq({tag, " an_onehot"}, 32'(bad_an), 0);
    check_eq({tag, " dp"}, 32'(bad_dp), 0);
  endtask

  task automatic run_value(input int v, input bit dn, input string tag);
    int len;
    @(negedge clk);
    sum_in  = 8'(v);
    done_in = dn;
    measure_busy(len);
    check_eq({tag, " busy_len"}, 32'(len), 9);
    last_val = v;
    check_frame(v, dn, tag);
  endtask

  initial begin
    int runs[$];
    int run_len;
    int v;
    bit dn;
    logic [3:0] exp_an;

    // Reset behaviour and refresh cadence.
    reset   = 1'b1;
    sum_in  = 8'd0;
    done_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset an", 32'(an), 32'(4'b1110));
    check_eq("reset seg", 32'(seg), 32'(7'b1000000));
    check_eq("reset dp", 32'(dp), 1);
    check_eq("reset busy", 32'(busy), 0);
    reset = 1'b0;
    for (int k = 1; k <= 4 * Div; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((k / Div) % 4));
      check_eq($sformatf("refresh an k=%0d", k), 32'(an), 32'(exp_an));
    end

    // Directed corner values.
    run_value(255, 1'b1, "max");
    run_value(7, 1'b0, "seven");
    run_value(0, 1'b1, "zero");

    // Change during conversion: 100, then 42 three cycles later.
    @(negedge clk);
    sum_in  = 8'd100;
    done_in = 1'b0;
    run_len = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) sum_in = 8'd42;
      if (busy) begin
        run_len++;
      end else if (run_len != 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
    check_eq("midchange bursts", 32'(runs.size()), 2);
    if (runs.size() == 2) begin
      check_eq("midchange burst0", 32'(runs[0]), 9);
      check_eq("midchange burst1", 32'(runs[1]), 9);
    end
    last_val = 42;
    check_frame(42, 1'b0, "midchange");

    // Reset asserted so it is sampled at E4 of a conversion of 200.
    @(negedge clk);
    sum_in = 8'd200;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midreset busy", 32'(busy), 0);
    check_eq("midreset an", 32'(an), 32'(4'b1110));
    check_eq("midreset seg", 32'(seg), 32'(7'b1000000));
    reset = 1'b0;
    begin
      int len;
      measure_busy(len);
      check_eq("midreset busy_len", 32'(len), 9);
    end
    last_val = 200;
    check_frame(200, 1'b0, "midreset");

    // Randomized sums and status flag.
    for (int n = 0; n < 8; n++) begin
      v = int'($urandom_range(255));
      while (v == last_val) v = int'($urandom_range(255));
      dn = 1'($urandom_range(1));
      run_value(v, dn, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
